// File: rtl/ram_clr_sync.sv
// rtl/ram_clr_sync.sv - single-port synchronous RAM with registered read and clear sequencer
module ram_clr_sync #(
    parameter int                ADDR_W         = 10,
    parameter int                DATA_W         = 10,
    parameter int                DEPTH          = 1024,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter bit                WRITE_THRU     = 1'b0
) (
    input  logic              clk,
    input  logic              clk_reset,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done,
    output logic              err
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam state_t            RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;
    localparam logic [ADDR_W:0]   DEPTH_EXT   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;
    logic              in_range;
    logic              acc_ok;
    logic              last;

    assign busy     = (state == CLEAR);
    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign acc_ok   = cs && !busy && in_range;
    assign last     = (clr_cnt == LAST_ADDR);

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (last) begin
                    clr_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clk_reset) begin
        if (clk_reset) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Array has no reset; the clear pass is the only initialisation.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt] <= CLEAR_VAL;
        end else if (acc_ok && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge clk_reset) begin
        if (clk_reset) begin
            rdata      <= '0;
            rvalid     <= 1'b0;
            clear_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            rvalid     <= 1'b0;
            err        <= cs && (busy || !in_range);
            clear_done <= busy && last;
            if (cs && !busy) begin
                if (!in_range) begin
                    if (!we) begin
                        rdata  <= '0;
                        rvalid <= 1'b1;
                    end
                end else if (!we) begin
                    rdata  <= mem[addr];
                    rvalid <= 1'b1;
                end else if (WRITE_THRU) begin
                    rdata  <= wdata;
                    rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_clr_sync.sv
// tb/tb_ram_clr_sync.sv - directed self-checking bench for ram_clr_sync
module tb_ram_clr_sync;

    logic       clk;
    logic       clk_reset;
    logic       we;
    logic [9:0] addr;
    logic [9:0] wdata;
    logic       cs0, cs1, cs2;
    logic       clear_req0, clear_req1, clear_req2;

    logic [9:0] rdata0, rdata1, rdata2;
    logic       rvalid0, rvalid1, rvalid2;
    logic       busy0, busy1, busy2;
    logic       clear_done0, clear_done1, clear_done2;
    logic       err0, err1, err2;

    int total;
    int bad;

    ram_clr_sync dut (
        .clk(clk), .clk_reset(clk_reset), .cs(cs0), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .rvalid(rvalid0), .clear_req(clear_req0), .busy(busy0),
        .clear_done(clear_done0), .err(err0)
    );

    ram_clr_sync #(.CLEAR_ON_RESET(1'b0), .WRITE_THRU(1'b1)) dut_wt (
        .clk(clk), .clk_reset(clk_reset), .cs(cs1), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .rvalid(rvalid1), .clear_req(clear_req1), .busy(busy1),
        .clear_done(clear_done1), .err(err1)
    );

    ram_clr_sync #(.DEPTH(1000), .CLEAR_VAL(10'h0AB)) dut_d1000 (
        .clk(clk), .clk_reset(clk_reset), .cs(cs2), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata2), .rvalid(rvalid2), .clear_req(clear_req2), .busy(busy2),
        .clear_done(clear_done2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n0, n2;
        bit d0, d2;
        logic cd0, cd2;
        clk_reset = 1'b1;
        repeat (3) tick();
        total++; if (rdata0 !== 10'h0) begin bad++; $display("FAIL rst_rdata got=%h want=000", rdata0); end
        total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", rvalid0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err0); end
        total++; if (clear_done0 !== 1'b0) begin bad++; $display("FAIL rst_clear_done got=%b want=0", clear_done0); end
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL rst_busy_cor1 got=%b want=1", busy0); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_busy_cor0 got=%b want=0", busy1); end
        clk_reset = 1'b0;
        n0 = 0; n2 = 0; d0 = 0; d2 = 0; cd0 = 1'b0; cd2 = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (!d0 && !busy0) begin d0 = 1; n0 = i + 1; cd0 = clear_done0; end
            if (!d2 && !busy2) begin d2 = 1; n2 = i + 1; cd2 = clear_done2; end
        end
        total++; if (n0 != 1024) begin bad++; $display("FAIL pass_len_1024 got=%0d want=1024", n0); end
        total++; if (cd0 !== 1'b1) begin bad++; $display("FAIL clear_done_1024 got=%b want=1", cd0); end
        total++; if (n2 != 1000) begin bad++; $display("FAIL pass_len_1000 got=%0d want=1000", n2); end
        total++; if (cd2 !== 1'b1) begin bad++; $display("FAIL clear_done_1000 got=%b want=1", cd2); end
        total++; if (clear_done0 !== 1'b0) begin bad++; $display("FAIL clear_done_pulse got=%b want=0", clear_done0); end
    endtask

    task automatic test_clear_reads();
        logic [9:0] a [3];
        a[0] = 10'd0; a[1] = 10'd511; a[2] = 10'd1023;
        for (int i = 0; i < 3; i++) begin
            cs0 = 1'b1; we = 1'b0; addr = a[i];
            tick();
            total++; if (rdata0 !== 10'h0) begin bad++; $display("FAIL clr_read_%0d got=%h want=000", a[i], rdata0); end
            total++; if (rvalid0 !== 1'b1) begin bad++; $display("FAIL clr_rvalid_%0d got=%b want=1", a[i], rvalid0); end
        end
        cs0 = 1'b0;
    endtask

    task automatic test_write_read();
        cs0 = 1'b1; cs1 = 1'b1; we = 1'b1; addr = 10'd5; wdata = 10'h2A5;
        tick();
        total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL wr_rvalid got=%b want=0", rvalid0); end
        total++; if (rdata0 !== 10'h0) begin bad++; $display("FAIL wr_rdata_hold got=%h want=000", rdata0); end
        total++; if (rvalid1 !== 1'b1) begin bad++; $display("FAIL wt_rvalid got=%b want=1", rvalid1); end
        total++; if (rdata1 !== 10'h2A5) begin bad++; $display("FAIL wt_rdata got=%h want=2a5", rdata1); end
        we = 1'b0;
        tick();
        total++; if (rdata0 !== 10'h2A5) begin bad++; $display("FAIL rd_after_wr got=%h want=2a5", rdata0); end
        total++; if (rvalid0 !== 1'b1) begin bad++; $display("FAIL rd_after_wr_rvalid got=%b want=1", rvalid0); end
        cs0 = 1'b0; cs1 = 1'b0;
        tick();
        total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL idle_rvalid got=%b want=0", rvalid0); end
        total++; if (rdata0 !== 10'h2A5) begin bad++; $display("FAIL idle_rdata_hold got=%h want=2a5", rdata0); end
    endtask

    task automatic test_clear_during_busy();
        int n, errs;
        cs0 = 1'b1; we = 1'b1; addr = 10'd3; wdata = 10'h155; clear_req0 = 1'b1;
        tick();
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL req_busy got=%b want=1", busy0); end
        cs0 = 1'b0; we = 1'b0; clear_req0 = 1'b0;
        n = 0; errs = 0;
        while (busy0 && n < 2000) begin
            case (n)
                10: begin cs0 = 1'b1; we = 1'b1; addr = 10'd5; wdata = 10'h3C3; end
                11: we = 1'b0;
                12: begin cs0 = 1'b0; clear_req0 = 1'b1; end
                13: clear_req0 = 1'b0;
                default: ;
            endcase
            tick();
            n++;
            if (err0 === 1'b1) errs++;
            if (n == 11) begin
                total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL busy_wr_rvalid got=%b want=0", rvalid0); end
            end
            if (n == 12) begin
                total++; if (err0 !== 1'b1) begin bad++; $display("FAIL busy_rd_err got=%b want=1", err0); end
                total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL busy_rd_rvalid got=%b want=0", rvalid0); end
                total++; if (rdata0 !== 10'h2A5) begin bad++; $display("FAIL busy_rd_hold got=%h want=2a5", rdata0); end
            end
        end
        total++; if (n != 1024) begin bad++; $display("FAIL busy_pass_len got=%0d want=1024", n); end
        total++; if (errs != 2) begin bad++; $display("FAIL busy_err_count got=%0d want=2", errs); end
        total++; if (clear_done0 !== 1'b1) begin bad++; $display("FAIL busy_clear_done got=%b want=1", clear_done0); end
        cs0 = 1'b1; we = 1'b0; addr = 10'd3;
        tick();
        total++; if (rdata0 !== 10'h0) begin bad++; $display("FAIL addr3_cleared got=%h want=000", rdata0); end
        total++; if (rvalid0 !== 1'b1) begin bad++; $display("FAIL addr3_rvalid got=%b want=1", rvalid0); end
        total++; if (clear_done0 !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b want=0", clear_done0); end
        addr = 10'd5;
        tick();
        total++; if (rdata0 !== 10'h0) begin bad++; $display("FAIL addr5_untouched got=%h want=000", rdata0); end
        cs0 = 1'b0;
    endtask

    task automatic test_out_of_range();
        cs2 = 1'b1; we = 1'b0; addr = 10'd999;
        tick();
        total++; if (rdata2 !== 10'h0AB) begin bad++; $display("FAIL d1000_last got=%h want=0ab", rdata2); end
        total++; if (err2 !== 1'b0) begin bad++; $display("FAIL d1000_last_err got=%b want=0", err2); end
        we = 1'b1; addr = 10'd1000; wdata = 10'h3FF;
        tick();
        total++; if (err2 !== 1'b1) begin bad++; $display("FAIL oor_wr_err got=%b want=1", err2); end
        total++; if (rvalid2 !== 1'b0) begin bad++; $display("FAIL oor_wr_rvalid got=%b want=0", rvalid2); end
        we = 1'b0;
        tick();
        total++; if (rdata2 !== 10'h0) begin bad++; $display("FAIL oor_rd_data got=%h want=000", rdata2); end
        total++; if (rvalid2 !== 1'b1) begin bad++; $display("FAIL oor_rd_rvalid got=%b want=1", rvalid2); end
        total++; if (err2 !== 1'b1) begin bad++; $display("FAIL oor_rd_err got=%b want=1", err2); end
        cs2 = 1'b0;
        tick();
        total++; if (err2 !== 1'b0) begin bad++; $display("FAIL oor_err_pulse got=%b want=0", err2); end
    endtask

    task automatic test_reset_mid_pass();
        int n, pulses;
        cs0 = 1'b1; we = 1'b1; addr = 10'd9; wdata = 10'h1C7;
        tick();
        we = 1'b0;
        tick();
        total++; if (rdata0 !== 10'h1C7) begin bad++; $display("FAIL pre_rst_read got=%h want=1c7", rdata0); end
        cs0 = 1'b0; clear_req0 = 1'b1;
        tick();
        clear_req0 = 1'b0;
        repeat (299) tick();
        cs0 = 1'b1;
        tick();
        cs0 = 1'b0;
        total++; if (err0 !== 1'b1) begin bad++; $display("FAIL mid_pass_err got=%b want=1", err0); end
        #2 clk_reset = 1'b1;
        #1;
        total++; if (rdata0 !== 10'h0) begin bad++; $display("FAIL async_rst_rdata got=%h want=000", rdata0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL async_rst_err got=%b want=0", err0); end
        total++; if (rdata1 !== 10'h0) begin bad++; $display("FAIL async_rst_rdata_wt got=%h want=000", rdata1); end
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL async_rst_busy got=%b want=1", busy0); end
        repeat (2) tick();
        total++; if (clear_done0 !== 1'b0) begin bad++; $display("FAIL rst_no_done got=%b want=0", clear_done0); end
        clk_reset = 1'b0;
        n = 0; pulses = 0;
        while (busy0 && n < 2000) begin
            tick();
            n++;
            if (clear_done0 === 1'b1) pulses++;
        end
        total++; if (n != 1024) begin bad++; $display("FAIL restart_pass_len got=%0d want=1024", n); end
        total++; if (pulses != 1) begin bad++; $display("FAIL restart_done_pulses got=%0d want=1", pulses); end
        cs0 = 1'b1; we = 1'b0; addr = 10'd9;
        tick();
        total++; if (rdata0 !== 10'h0) begin bad++; $display("FAIL restart_addr9 got=%h want=000", rdata0); end
        cs0 = 1'b0;
        repeat (30) tick();
    endtask

    initial begin
        total = 0; bad = 0;
        clk_reset = 1'b1;
        we = 1'b0; addr = '0; wdata = '0;
        cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
        clear_req0 = 1'b0; clear_req1 = 1'b0; clear_req2 = 1'b0;
        test_reset();
        test_clear_reads();
        test_write_read();
        test_clear_during_busy();
        test_out_of_range();
        test_reset_mid_pass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
